// File: rtl/cic_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cic_ctrl_pkg
// Shared definitions for the CIC stream controller:
//   - state_e  : controller FSM states (IDLE, RUN, DRAIN, DONE, ERR)
//   - ERR_*    : err_code values reported by the controller
//   - default widths / decimation ratio used as parameter defaults
// ---------------------------------------------------------------------------
package cic_ctrl_pkg;

  localparam int FLEN_W_DEF = 16;
  localparam int DECIM_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CORE = 2'b01;
  localparam logic [1:0] ERR_WDOG = 2'b10;

endpackage : cic_ctrl_pkg

// File: rtl/cic_wdog.sv
// ---------------------------------------------------------------------------
// cic_wdog
// Counts accepted input beats since the last accepted output beat and flags
// the beat that brings the count to LIMIT. The counter saturates at LIMIT.
// Ports:
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   restart  in  hold the count at zero (controller not streaming)
//   inc      in  an input beat was accepted this cycle
//   clr      in  an output beat was accepted this cycle (core is alive)
//   hit      out this cycle's input beat reaches LIMIT (combinational)
// ---------------------------------------------------------------------------
module cic_wdog #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam int CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // An accepted output beat in the same cycle proves the core is producing,
  // so it overrides the increment and suppresses the hit.
  assign hit = inc && !clr && !restart && (cnt_q >= CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (restart || clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : cic_wdog

// File: rtl/cic_stream_ctrl.sv
// ---------------------------------------------------------------------------
// cic_stream_ctrl
// Handshake controller around a CIC decimator core. Sample/result data run
// outside this block (source -> core -> sink); only valid/ready, the core
// clock enable, end-of-packet tagging, frame completion and error reporting
// are handled here.
//
// Build option: define CIC_STREAM_CTRL_WDOG_EN to include the input watchdog
// (cic_wdog). Without it err_code can only be ERR_NONE or ERR_CORE.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   start, stop, clear      frame start / early stop / error clear pulses
//   frame_len[FLEN_W]       output beats per frame, sampled on accepted start
//   src_valid / src_ready   source handshake
//   cic_clken               core clock enable
//   cic_in_valid/_ready     core input handshake, cic_in_error tied to 00
//   cic_out_valid/_ready    core output handshake, cic_out_error = fault status
//   snk_valid/_ready/_eop   sink handshake with last-beat marker
//   done                    one-cycle frame-complete pulse
//   err_code                00 none, 01 core fault, 10 watchdog
// ---------------------------------------------------------------------------
module cic_stream_ctrl
  import cic_ctrl_pkg::*;
#(
  parameter int FLEN_W = FLEN_W_DEF,
  parameter int DECIM  = DECIM_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic [FLEN_W-1:0] frame_len,
  input  logic              src_valid,
  output logic              src_ready,
  output logic              cic_clken,
  output logic              cic_in_valid,
  input  logic              cic_in_ready,
  output logic [1:0]        cic_in_error,
  input  logic              cic_out_valid,
  output logic              cic_out_ready,
  input  logic [1:0]        cic_out_error,
  output logic              snk_valid,
  input  logic              snk_ready,
  output logic              snk_eop,
  output logic              done,
  output logic [1:0]        err_code
);

  state_e            state_q, state_d;
  logic [FLEN_W-1:0] len_q, len_d;
  logic [FLEN_W-1:0] beat_q, beat_d;
  logic              done_q, done_d;
  logic [1:0]        err_q, err_d;

  logic active;
  logic out_acc;
  logic fault;
  logic last_beat;
  logic wdog_hit;

  // DECIM only sizes the optional watchdog; keep it referenced in all builds.
  logic unused_decim;
  assign unused_decim = ^DECIM;

  // Handshakes are combinational pass-throughs gated by state so the data
  // path sees zero added latency.
  assign active        = (state_q == RUN) || (state_q == DRAIN);
  assign cic_clken     = active;
  assign cic_in_valid  = (state_q == RUN) && src_valid;
  assign src_ready     = (state_q == RUN) && cic_in_ready;
  assign cic_in_error  = 2'b00;
  assign snk_valid     = active && cic_out_valid && (cic_out_error == 2'b00);
  assign cic_out_ready = active && snk_ready;

  // A faulted core beat is never forwarded; the core may still consume it
  // through cic_out_ready, which is how it gets dropped.
  assign fault     = active && cic_out_valid && (cic_out_error != 2'b00);
  assign out_acc   = snk_valid && snk_ready;
  assign last_beat = (state_q == DRAIN) || (beat_q == (len_q - 1'b1));
  assign snk_eop   = snk_valid && last_beat;

`ifdef CIC_STREAM_CTRL_WDOG_EN
  logic in_acc;
  assign in_acc = cic_in_valid && src_ready;

  cic_wdog #(
    .LIMIT (2 * DECIM)
  ) u_wdog (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (!active),
    .inc     (in_acc),
    .clr     (out_acc),
    .hit     (wdog_hit)
  );
`else
  assign wdog_hit = 1'b0;
`endif

  assign done     = done_q;
  assign err_code = err_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    beat_d  = beat_q;
    done_d  = 1'b0;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (start && (frame_len != '0)) begin
          state_d = RUN;
          len_d   = frame_len;
          beat_d  = '0;
        end
      end

      RUN, DRAIN: begin
        // Priority: fault > watchdog > eop > stop.
        if (fault) begin
          state_d = ERR;
          err_d   = ERR_CORE;
        end else if (wdog_hit) begin
          state_d = ERR;
          err_d   = ERR_WDOG;
        end else begin
          if (out_acc && (beat_q != '1)) begin
            beat_d = beat_q + 1'b1;
          end
          if (out_acc && last_beat) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if ((state_q == RUN) && stop) begin
            state_d = DRAIN;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      ERR: begin
        if (clear) begin
          state_d = IDLE;
          err_d   = ERR_NONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      beat_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule : cic_stream_ctrl

// File: tb/tb_cic_stream_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cic_stream_ctrl
// Directed bench for cic_stream_ctrl: normal frame, sink backpressure,
// early stop, core fault + clear, watchdog (or its absence) and async reset.
// ---------------------------------------------------------------------------
module tb_cic_stream_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, stop, clear;
  logic [15:0] frame_len;
  logic        src_valid, src_ready;
  logic        cic_clken, cic_in_valid, cic_in_ready;
  logic [1:0]  cic_in_error;
  logic        cic_out_valid, cic_out_ready;
  logic [1:0]  cic_out_error;
  logic        snk_valid, snk_ready, snk_eop;
  logic        done;
  logic [1:0]  err_code;

  int n_chk = 0;
  int n_err = 0;
  int acc;

  always #5 clk = ~clk;

  cic_stream_ctrl #(.FLEN_W(16), .DECIM(8)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .stop          (stop),
    .clear         (clear),
    .frame_len     (frame_len),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .cic_clken     (cic_clken),
    .cic_in_valid  (cic_in_valid),
    .cic_in_ready  (cic_in_ready),
    .cic_in_error  (cic_in_error),
    .cic_out_valid (cic_out_valid),
    .cic_out_ready (cic_out_ready),
    .cic_out_error (cic_out_error),
    .snk_valid     (snk_valid),
    .snk_ready     (snk_ready),
    .snk_eop       (snk_eop),
    .done          (done),
    .err_code      (err_code)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    frame_len = 16'd0; src_valid = 1'b1; cic_in_ready = 1'b1;
    cic_out_valid = 1'b1; cic_out_error = 2'b00; snk_ready = 1'b1;

    // Reset state with all inputs asking for activity
    #12;
    chk("rst_src_ready", 32'(src_ready), 32'd0);
    chk("rst_in_valid",  32'(cic_in_valid), 32'd0);
    chk("rst_clken",     32'(cic_clken), 32'd0);
    chk("rst_snk_valid", 32'(snk_valid), 32'd0);
    chk("rst_out_ready", 32'(cic_out_ready), 32'd0);
    chk("rst_done",      32'(done), 32'd0);
    chk("rst_err",       32'(err_code), 32'd0);
    chk("rst_in_error",  32'(cic_in_error), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("idle_clken", 32'(cic_clken), 32'd0);
    chk("idle_src_ready", 32'(src_ready), 32'd0);

    // Normal frame: length 4, continuous flow
    frame_len = 16'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("f1_clken", 32'(cic_clken), 32'd1);
      chk("f1_src_ready", 32'(src_ready), 32'd1);
      chk("f1_in_valid", 32'(cic_in_valid), 32'd1);
      chk("f1_snk_valid", 32'(snk_valid), 32'd1);
      chk("f1_eop", 32'(snk_eop), (i == 3) ? 32'd1 : 32'd0);
      tick();
    end
    #1;
    chk("f1_done", 32'(done), 32'd1);
    chk("f1_done_clken", 32'(cic_clken), 32'd0);
    chk("f1_done_snk_valid", 32'(snk_valid), 32'd0);
    tick();
    chk("f1_done_off", 32'(done), 32'd0);
    chk("f1_idle_src_ready", 32'(src_ready), 32'd0);

    // Sink backpressure: length 3, snk_ready toggles
    src_valid = 1'b0; cic_out_valid = 1'b0;
    frame_len = 16'd3; start = 1'b1;
    tick();
    start = 1'b0; cic_out_valid = 1'b1; acc = 0;
    for (int i = 0; i < 5; i++) begin
      snk_ready = (i % 2 == 0);
      #1;
      chk("f2_snk_valid", 32'(snk_valid), 32'd1);
      chk("f2_out_ready", 32'(cic_out_ready), 32'(snk_ready));
      chk("f2_eop", 32'(snk_eop), (acc == 2) ? 32'd1 : 32'd0);
      if (snk_ready) acc++;
      tick();
    end
    #1;
    chk("f2_done", 32'(done), 32'd1);
    tick();
    chk("f2_done_off", 32'(done), 32'd0);
    cic_out_valid = 1'b0; snk_ready = 1'b1;

    // Early stop: length 10, stop after one beat
    frame_len = 16'd10; start = 1'b1;
    tick();
    start = 1'b0; cic_out_valid = 1'b1;
    #1;
    chk("f3_beat1_valid", 32'(snk_valid), 32'd1);
    chk("f3_beat1_eop", 32'(snk_eop), 32'd0);
    tick();
    cic_out_valid = 1'b0; stop = 1'b1; src_valid = 1'b1; cic_in_ready = 1'b1;
    #1;
    chk("f3_run_src_ready", 32'(src_ready), 32'd1);
    tick();
    stop = 1'b0;
    #1;
    chk("f3_drain_src_ready", 32'(src_ready), 32'd0);
    chk("f3_drain_in_valid", 32'(cic_in_valid), 32'd0);
    chk("f3_drain_clken", 32'(cic_clken), 32'd1);
    chk("f3_drain_snk_valid", 32'(snk_valid), 32'd0);
    tick();
    cic_out_valid = 1'b1;
    #1;
    chk("f3_drain_eop", 32'(snk_eop), 32'd1);
    chk("f3_drain_src_ready2", 32'(src_ready), 32'd0);
    tick();
    chk("f3_done", 32'(done), 32'd1);
    tick();
    cic_out_valid = 1'b0; src_valid = 1'b0;

    // Core fault on 2nd beat, then clear
    frame_len = 16'd4; start = 1'b1;
    tick();
    start = 1'b0; cic_out_valid = 1'b1;
    #1;
    chk("f4_beat1_valid", 32'(snk_valid), 32'd1);
    tick();
    cic_out_error = 2'b10;
    #1;
    chk("f4_fault_snk_valid", 32'(snk_valid), 32'd0);
    chk("f4_fault_err_pre", 32'(err_code), 32'd0);
    tick();
    cic_out_error = 2'b00; cic_out_valid = 1'b0;
    #1;
    chk("f4_err_code", 32'(err_code), 32'd1);
    chk("f4_err_clken", 32'(cic_clken), 32'd0);
    chk("f4_err_src_ready", 32'(src_ready), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("f4_start_ignored_err", 32'(err_code), 32'd1);
    chk("f4_start_ignored_clken", 32'(cic_clken), 32'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("f4_cleared_err", 32'(err_code), 32'd0);
    chk("f4_cleared_clken", 32'(cic_clken), 32'd0);
    frame_len = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("f4_zero_len_ignored", 32'(cic_clken), 32'd0);

    // Watchdog: 16 accepted inputs, no output
    frame_len = 16'd4; start = 1'b1;
    tick();
    start = 1'b0; src_valid = 1'b1; cic_in_ready = 1'b1; cic_out_valid = 1'b0;
    repeat (15) tick();
    chk("f5_15_err", 32'(err_code), 32'd0);
    chk("f5_15_src_ready", 32'(src_ready), 32'd1);
    tick();
`ifdef CIC_STREAM_CTRL_WDOG_EN
    chk("f5_wdog_err", 32'(err_code), 32'd2);
    chk("f5_wdog_src_ready", 32'(src_ready), 32'd0);
`else
    chk("f5_nowdog_err", 32'(err_code), 32'd0);
    chk("f5_nowdog_src_ready", 32'(src_ready), 32'd1);
`endif
    clear = 1'b1;
    tick();
    clear = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; cic_out_valid = 1'b1; cic_out_error = 2'b11;
    chk("f5_running", 32'(cic_clken), 32'd1);

    // Asynchronous reset mid-frame
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_clken", 32'(cic_clken), 32'd0);
    chk("ar_src_ready", 32'(src_ready), 32'd0);
    chk("ar_err", 32'(err_code), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    chk("ar_snk_valid", 32'(snk_valid), 32'd0);
    cic_out_error = 2'b00;
    chk("ar_snk_valid_noerr", 32'(snk_valid), 32'd0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("ar_post_clken", 32'(cic_clken), 32'd0);
    chk("ar_post_src_ready", 32'(src_ready), 32'd0);
    tick();
    chk("ar_idle_clken", 32'(cic_clken), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_cic_stream_ctrl

// File: doc/cic_stream_ctrl.md
CIC_STREAM_CTRL -- requirements
Module: cic_stream_ctrl
Interface
REQ-001 FLEN_W, 16, width of frame_len and the output beat counter.
REQ-002 DECIM, 8, CIC decimation ratio; watchdog limit = 2*DECIM accepted input beats.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  frame start pulse.
REQ-006 stop  in  1  early-stop pulse.
REQ-007 clear  in  1  error-clear pulse.
REQ-008 frame_len  in  FLEN_W  output beats per frame, sampled on accepted start.
REQ-009 src_valid  in  1  source sample valid.
REQ-010 src_ready  out  1  source may advance.
REQ-011 cic_clken  out  1  CIC core clock enable.
REQ-012 cic_in_valid  out  1  core input valid.
REQ-013 cic_in_ready  in  1  core accepts input.
REQ-014 cic_in_error  out  2  core input status, constant 2'b00.
REQ-015 cic_out_valid  in  1  core output valid.
REQ-016 cic_out_ready  out  1  core output may advance.
REQ-017 cic_out_error  in  2  core output status; nonzero = fault.
REQ-018 snk_valid  out  1  sink beat valid.
REQ-019 snk_ready  in  1  sink accepts beat.
REQ-020 snk_eop  out  1  last beat of frame, qualified by snk_valid.
REQ-021 done  out  1  one-cycle registered frame-complete pulse.
REQ-022 err_code  out  2  registered: 00 none, 01 core fault, 10 watchdog.
Function
REQ-023 Sample and result data wires run outside this block (source->core->sink); the block controls handshakes only.
REQ-024 States: IDLE, RUN, DRAIN, DONE, ERR; encoding is the FSM state register.
REQ-025 IDLE: src_ready=0, cic_in_valid=0, cic_out_ready=0, snk_valid=0, cic_clken=0.
REQ-026 IDLE->RUN on start with frame_len!=0; latches frame_len, zeroes beat and watchdog counters; start with frame_len==0 is ignored.
REQ-027 RUN/DRAIN: cic_clken=1; cic_in_valid=src_valid and src_ready=cic_in_ready (combinational, zero latency); input accepted when both high.
REQ-028 RUN/DRAIN: snk_valid=cic_out_valid && cic_out_error==0; cic_out_ready=snk_ready; output beat accepted when snk_valid && snk_ready.
REQ-029 Beat counter increments per accepted output beat; snk_eop=1 when count==latched length-1 in RUN, or on any beat in DRAIN.
REQ-030 Accepted eop beat -> DONE; DONE asserts done for exactly one cycle, then -> IDLE.
REQ-031 RUN->DRAIN on stop; DRAIN stops input (src_ready=0, cic_in_valid=0) and waits for the next valid output beat, tagged eop.
REQ-032 Watchdog counts accepted input beats, clears on each accepted output beat; reaching 2*DECIM -> ERR, err_code=10.
REQ-033 cic_out_valid with cic_out_error!=0 in RUN/DRAIN: beat dropped, -> ERR, err_code=01.
REQ-034 ERR: all handshake outputs 0, cic_clken=0, err_code held; clear -> IDLE with err_code=00.
REQ-035 Priority in one cycle: fault > watchdog > eop > stop; start outside IDLE and clear outside ERR are ignored.
REQ-036 Counters saturate at their maximum and never wrap.
Reset
REQ-037 Asserting reset_n low forces IDLE asynchronously at any time, including mid-frame; done=0, err_code=00, all counters 0.
REQ-038 All outputs hold IDLE values until the first clk edge after reset_n is deasserted.
Configuration
REQ-039 With CIC_STREAM_CTRL_WDOG_EN defined, REQ-032 is in force; undefined, the watchdog logic is absent and err_code never equals 10.
Structure
REQ-040 Package cic_ctrl_pkg holds the state enum, the err_code constants (ERR_NONE, ERR_CORE, ERR_WDOG) and default widths.
REQ-041 Watchdog is sub-module cic_wdog (count, clear, limit-hit), instantiated only under CIC_STREAM_CTRL_WDOG_EN.
Verification
REQ-042 frame_len=4, DECIM=8, continuous src_valid, snk_ready=1 -> 4 snk beats, eop on the 4th, done pulse, state IDLE.
REQ-043 frame_len=3, snk_ready toggled 1/0 each cycle -> no beat lost or duplicated, eop on the 3rd accepted beat.
REQ-044 stop after 1 output beat, frame_len=10 -> next beat carries eop, done pulses, src_ready=0 after stop.
REQ-045 cic_out_error=2'b10 on the 2nd output beat -> beat not forwarded, err_code=01; clear -> IDLE, err_code=00.
REQ-046 WDOG_EN defined, 16 inputs accepted with no output -> err_code=10; reset_n low mid-frame -> IDLE, outputs 0.
